instr_feeder: RTL

INSTR_FEEDER -- requirements
Module: instr_feeder

---
 rtl/instr_feeder.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/instr_feeder.sv
// ---------------------------------------------------------------------------
// instr_feeder
//
// Holds a small program loaded word by word, then issues it in order to a
// core with a valid/ready handshake. The number of issued but not yet
// committed instructions is capped at ROB_SIZE.
//
// Optional feature macro: INSTR_FEEDER_PERF_EN adds o_cycles, a saturating
// count of RUN/DRAIN cycles for the current run.
//
// Ports
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_load_valid/data   loader word into the store (accepted in IDLE only)
//   o_load_ready        store has room and the feeder is in IDLE
//   i_start             begin / restart issue (pulse)
//   i_clear             discard program, return to IDLE (pulse, wins over start)
//   o_instr_valid/o_instr, i_instr_ready   issue handshake to the core
//   i_commit            core retired one instruction
//   o_pc                index of next word to issue
//   o_inflight          issued but uncommitted instructions
//   o_busy              RUN or DRAIN
//   o_done              whole program committed
//   o_err               sticky: commit seen with nothing in flight
//   o_cycles            (INSTR_FEEDER_PERF_EN only) RUN/DRAIN cycle count
// ---------------------------------------------------------------------------
module instr_feeder #(
    parameter int DEPTH    = 16,
    parameter int ROB_SIZE = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int IW = $clog2(ROB_SIZE + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_load_valid,
    input  logic [31:0]   i_load_data,
    output logic          o_load_ready,
    input  logic          i_start,
    input  logic          i_clear,
    output logic          o_instr_valid,
    output logic [31:0]   o_instr,
    input  logic          i_instr_ready,
    input  logic          i_commit,
    output logic [AW:0]   o_pc,
    output logic [IW-1:0] o_inflight,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
`ifdef INSTR_FEEDER_PERF_EN
    ,
    output logic [31:0]   o_cycles
`endif
);

    localparam logic [AW:0]   DEPTH_V = (AW + 1)'(DEPTH);
    localparam logic [IW-1:0] ROB_V   = IW'(ROB_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t        state;
    logic [31:0]   store [DEPTH];
    logic [AW:0]   count;
    logic [AW:0]   pc;
    logic [AW:0]   committed;
    logic [IW-1:0] inflight;

    logic          load_fire;
    logic          issue;
    logic          commit_ok;
    logic          commit_err;
    logic          start_ok;
    logic          drained;
    logic [AW:0]   pc_nx;
    logic [AW:0]   committed_nx;
    logic [IW-1:0] inflight_nx;

    always_comb begin
        o_load_ready  = (state == IDLE) && (count < DEPTH_V);
        load_fire     = i_load_valid && o_load_ready;

        o_instr_valid = (state == RUN) && (pc < count) && (inflight < ROB_V);
        // Gated so the output is zero whenever nothing is offered; the store
        // itself is never reset.
        o_instr       = o_instr_valid ? store[pc[AW-1:0]] : '0;
        issue         = o_instr_valid && i_instr_ready;

        // A commit is legal if something is in flight, or if it retires the
        // instruction issued in this same cycle.
        commit_ok     = i_commit && ((inflight != '0) || issue);
        commit_err    = i_commit && !commit_ok;

        pc_nx         = pc + (AW + 1)'(issue);
        committed_nx  = committed + (AW + 1)'(commit_ok);
        inflight_nx   = inflight;
        if (issue && !commit_ok) begin
            inflight_nx = inflight + IW'(1);
        end else if (commit_ok && !issue) begin
            inflight_nx = inflight - IW'(1);
        end

        // Evaluated on next-cycle values so DONE follows the final commit
        // by exactly one cycle.
        drained       = (inflight_nx == '0) && (committed_nx == count);

        start_ok      = i_start && !i_clear &&
                        (((state == IDLE) && (count != '0)) || (state == DONE));

        o_busy        = (state == RUN) || (state == DRAIN);
        o_done        = (state == DONE);
        o_pc          = pc;
        o_inflight    = inflight;
    end

    // Program store: written only while loading, unreachable beyond count.
    always_ff @(posedge i_clk) begin
        if (load_fire) begin
            store[count[AW-1:0]] <= i_load_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            count     <= '0;
            pc        <= '0;
            committed <= '0;
            inflight  <= '0;
            o_err     <= 1'b0;
        end else begin
            if (commit_err) begin
                o_err <= 1'b1;
            end
            if (i_clear) begin
                state     <= IDLE;
                count     <= '0;
                pc        <= '0;
                committed <= '0;
                inflight  <= '0;
            end else begin
                pc        <= pc_nx;
                committed <= committed_nx;
                inflight  <= inflight_nx;
                case (state)
                    IDLE: begin
                        if (load_fire) begin
                            count <= count + (AW + 1)'(1);
                        end
                        if (start_ok) begin
                            state     <= RUN;
                            pc        <= '0;
                            committed <= '0;
                        end
                    end
                    RUN: begin
                        // If the last commit lands in the same cycle the
                        // pc==count condition is seen, DRAIN has nothing to
                        // wait for and is skipped.
                        if (pc == count) begin
                            state <= drained ? DONE : DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (drained) begin
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        if (start_ok) begin
                            state     <= RUN;
                            pc        <= '0;
                            committed <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef INSTR_FEEDER_PERF_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_cycles <= '0;
        end else if (start_ok) begin
            o_cycles <= '0;
        end else if (o_busy && (o_cycles != '1)) begin
            o_cycles <= o_cycles + 32'd1;
        end
    end
`endif

endmodule
